// File: rtl/minterm_sweep_checker_if.sv
// Sweep/check bus between the sequencer, the function under test and its observer.
// The master side drives start/expected/f_in; the slave (checker) drives the vector and results.
interface minterm_sweep_checker_if #(parameter int N = 4);
  localparam int W = 1 << N;

  logic          start;
  logic [W-1:0]  expected;
  logic          f_in;
  logic [N-1:0]  vec_out;
  logic          busy;
  logic          done;
  logic          pass;
  logic [W-1:0]  truth_table;
  logic [N:0]    mismatch_cnt;
  logic [N-1:0]  first_bad;
  logic          first_bad_valid;

  modport master (
    output start, expected, f_in,
    input  vec_out, busy, done, pass, truth_table, mismatch_cnt, first_bad, first_bad_valid
  );

  modport slave (
    input  start, expected, f_in,
    output vec_out, busy, done, pass, truth_table, mismatch_cnt, first_bad, first_bad_valid
  );
endinterface

// File: rtl/minterm_sweep_checker.sv
// Clocked sweep of all 2^N input vectors into a combinational F, holding each DWELL clocks,
// capturing the truth table and scoring it against a minterm mask latched at start.
module minterm_sweep_checker #(
  parameter int N     = 4,
  parameter int DWELL = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  minterm_sweep_checker_if.slave bus
);
  localparam int         W        = 1 << N;
  localparam logic [7:0] DWELL_M1 = 8'(DWELL - 1);
  localparam logic [N:0] CNT_MAX  = (N+1)'(W);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t       state, state_nxt;
  logic [N-1:0] idx;
  logic [7:0]   dwell_cnt;
  logic [W-1:0] exp_q;
  logic [W-1:0] truth_table;
  logic [N:0]   mismatch_cnt;
  logic [N-1:0] first_bad;
  logic         first_bad_valid;
  logic         accept, sample, last, busy, done, pass;

  assign accept = bus.start && (state != RUN);
  assign sample = (state == RUN) && (dwell_cnt == DWELL_M1);
  assign last   = (idx == {N{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start)     state_nxt = RUN;
      RUN:     if (sample && last) state_nxt = DONE;
      DONE:    if (bus.start)     state_nxt = RUN;
      default:                    state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (state)
      RUN:  busy = 1'b1;
      DONE: begin
        done = 1'b1;
        pass = (mismatch_cnt == '0);
      end
      default: ;
    endcase
  end

  // Datapath: idx doubles as the registered vector, so it parks at 2^N-1 in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      dwell_cnt       <= '0;
      exp_q           <= '0;
      truth_table     <= '0;
      mismatch_cnt    <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else if (accept) begin
      idx             <= '0;
      dwell_cnt       <= '0;
      exp_q           <= bus.expected;
      truth_table     <= '0;
      mismatch_cnt    <= '0;
      first_bad       <= '0;
      first_bad_valid <= 1'b0;
    end else if (state == RUN) begin
      if (!sample) begin
        dwell_cnt <= dwell_cnt + 8'd1;
      end else begin
        truth_table[idx] <= bus.f_in;
        if (bus.f_in != exp_q[idx]) begin
          if (mismatch_cnt != CNT_MAX) mismatch_cnt <= mismatch_cnt + (N+1)'(1);
          if (!first_bad_valid) begin
            first_bad       <= idx;
            first_bad_valid <= 1'b1;
          end
        end
        if (!last) begin
          idx       <= idx + N'(1);
          dwell_cnt <= '0;
        end
      end
    end
  end

  assign bus.vec_out         = idx;
  assign bus.busy            = busy;
  assign bus.done            = done;
  assign bus.pass            = pass;
  assign bus.truth_table     = truth_table;
  assign bus.mismatch_cnt    = mismatch_cnt;
  assign bus.first_bad       = first_bad;
  assign bus.first_bad_valid = first_bad_valid;
endmodule

// File: tb/tb_minterm_sweep_checker.sv
// Directed bench: a DWELL=4 and a DWELL=1 checker, each wrapped around a modelled F.
module tb_minterm_sweep_checker;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   mode4  = 0;  // 0: XOR, 1: stuck-at-0, 2: XNOR
  int   mode1  = 0;

  always #5 clk = ~clk;

  minterm_sweep_checker_if #(.N(4)) b4 ();
  minterm_sweep_checker_if #(.N(4)) b1 ();

  assign b4.f_in = (mode4 == 0) ? ^b4.vec_out : (mode4 == 1) ? 1'b0 : ~^b4.vec_out;
  assign b1.f_in = (mode1 == 0) ? ^b1.vec_out : (mode1 == 1) ? 1'b0 : ~^b1.vec_out;

  minterm_sweep_checker #(.N(4), .DWELL(4)) dut4 (.clk(clk), .rst(rst), .bus(b4));
  minterm_sweep_checker #(.N(4), .DWELL(1)) dut1 (.clk(clk), .rst(rst), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after E0.
  task automatic start4();
    b4.start = 1'b1;
    tick();
    b4.start = 1'b0;
  endtask

  // Advance until done, from edge count e0; capped so a stuck DUT cannot hang the run.
  task automatic wait_done4(input int e0, output int e);
    e = e0;
    while (!b4.done && e < e0 + 200) begin
      tick();
      e++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++; if (b4.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b want 0", b4.busy); end
    checks++; if (b4.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", b4.done); end
    checks++; if (b4.pass !== 1'b0) begin errors++; $display("FAIL reset_pass: got %0b want 0", b4.pass); end
    checks++; if (b4.vec_out !== 4'd0) begin errors++; $display("FAIL reset_vec: got %0d want 0", b4.vec_out); end
    checks++; if (b4.truth_table !== 16'h0 || b4.mismatch_cnt !== 5'd0 || b4.first_bad !== 4'd0 || b4.first_bad_valid !== 1'b0) begin
      errors++; $display("FAIL reset_results: tt=%h cnt=%0d fb=%0d fbv=%0b want all 0", b4.truth_table, b4.mismatch_cnt, b4.first_bad, b4.first_bad_valid);
    end
    rst = 1'b0;
    tick();
    checks++; if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin errors++; $display("FAIL idle_hold: busy=%0b done=%0b want 0 0", b4.busy, b4.done); end
  endtask

  task automatic test_pass();
    int e;
    mode4 = 0; b4.expected = 16'h6996;
    start4();
    checks++; if (b4.busy !== 1'b1 || b4.vec_out !== 4'd0) begin errors++; $display("FAIL pass_e0: busy=%0b vec=%0d want 1 0", b4.busy, b4.vec_out); end
    repeat (3) tick();
    checks++; if (b4.vec_out !== 4'd0) begin errors++; $display("FAIL pass_e3_vec: got %0d want 0", b4.vec_out); end
    tick();
    checks++; if (b4.vec_out !== 4'd1) begin errors++; $display("FAIL pass_e4_vec: got %0d want 1", b4.vec_out); end
    wait_done4(4, e);
    checks++; if (e !== 64) begin errors++; $display("FAIL pass_latency: done after E%0d want E64", e); end
    checks++; if (b4.truth_table !== 16'h6996) begin errors++; $display("FAIL pass_tt: got %h want 6996", b4.truth_table); end
    checks++; if (b4.mismatch_cnt !== 5'd0 || b4.pass !== 1'b1 || b4.first_bad_valid !== 1'b0) begin
      errors++; $display("FAIL pass_result: cnt=%0d pass=%0b fbv=%0b want 0 1 0", b4.mismatch_cnt, b4.pass, b4.first_bad_valid);
    end
    checks++; if (b4.busy !== 1'b0 || b4.vec_out !== 4'd15) begin errors++; $display("FAIL pass_done_state: busy=%0b vec=%0d want 0 15", b4.busy, b4.vec_out); end
  endtask

  task automatic test_stuck0();
    int e;
    mode4 = 1; b4.expected = 16'h6996;
    start4();
    wait_done4(0, e);
    checks++; if (e !== 64) begin errors++; $display("FAIL stuck_latency: done after E%0d want E64", e); end
    checks++; if (b4.truth_table !== 16'h0) begin errors++; $display("FAIL stuck_tt: got %h want 0000", b4.truth_table); end
    checks++; if (b4.mismatch_cnt !== 5'd8) begin errors++; $display("FAIL stuck_cnt: got %0d want 8", b4.mismatch_cnt); end
    checks++; if (b4.first_bad !== 4'd1 || b4.first_bad_valid !== 1'b1 || b4.pass !== 1'b0) begin
      errors++; $display("FAIL stuck_first: fb=%0d fbv=%0b pass=%0b want 1 1 0", b4.first_bad, b4.first_bad_valid, b4.pass);
    end
  endtask

  task automatic test_all_wrong();
    int e;
    mode4 = 2; b4.expected = 16'h6996;
    start4();
    wait_done4(0, e);
    checks++; if (b4.mismatch_cnt !== 5'b10000) begin errors++; $display("FAIL allwrong_cnt: got %0d want 16", b4.mismatch_cnt); end
    checks++; if (b4.truth_table !== 16'h9669) begin errors++; $display("FAIL allwrong_tt: got %h want 9669", b4.truth_table); end
    checks++; if (b4.first_bad !== 4'd0 || b4.first_bad_valid !== 1'b1 || b4.pass !== 1'b0) begin
      errors++; $display("FAIL allwrong_first: fb=%0d fbv=%0b pass=%0b want 0 1 0", b4.first_bad, b4.first_bad_valid, b4.pass);
    end
  endtask

  task automatic test_ignored_inputs();
    int e;
    mode4 = 0; b4.expected = 16'h6996;
    start4();
    repeat (20) tick();
    b4.start = 1'b1; b4.expected = 16'hFFFF;
    tick();
    b4.start = 1'b0;
    checks++; if (b4.busy !== 1'b1 || b4.vec_out !== 4'd5) begin errors++; $display("FAIL ignore_e21: busy=%0b vec=%0d want 1 5", b4.busy, b4.vec_out); end
    wait_done4(21, e);
    checks++; if (e !== 64) begin errors++; $display("FAIL ignore_latency: done after E%0d want E64", e); end
    checks++; if (b4.truth_table !== 16'h6996 || b4.mismatch_cnt !== 5'd0 || b4.pass !== 1'b1) begin
      errors++; $display("FAIL ignore_result: tt=%h cnt=%0d pass=%0b want 6996 0 1", b4.truth_table, b4.mismatch_cnt, b4.pass);
    end
  endtask

  task automatic test_reset_mid();
    int e;
    mode4 = 1; b4.expected = 16'h6996;
    start4();
    repeat (30) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (b4.busy !== 1'b0 || b4.done !== 1'b0 || b4.vec_out !== 4'd0) begin
      errors++; $display("FAIL midrst_state: busy=%0b done=%0b vec=%0d want 0 0 0", b4.busy, b4.done, b4.vec_out);
    end
    checks++; if (b4.truth_table !== 16'h0 || b4.mismatch_cnt !== 5'd0 || b4.first_bad_valid !== 1'b0 || b4.first_bad !== 4'd0) begin
      errors++; $display("FAIL midrst_results: tt=%h cnt=%0d fb=%0d fbv=%0b want all 0", b4.truth_table, b4.mismatch_cnt, b4.first_bad, b4.first_bad_valid);
    end
    mode4 = 0;
    start4();
    wait_done4(0, e);
    checks++; if (e !== 64 || b4.pass !== 1'b1 || b4.truth_table !== 16'h6996) begin
      errors++; $display("FAIL midrst_resweep: done E%0d pass=%0b tt=%h want E64 1 6996", e, b4.pass, b4.truth_table);
    end
  endtask

  task automatic test_restart_dwell1();
    int e;
    checks++; if (b4.done !== 1'b1 || b4.pass !== 1'b1) begin errors++; $display("FAIL restart_pre: done=%0b pass=%0b want 1 1", b4.done, b4.pass); end
    start4();
    checks++; if (b4.done !== 1'b0 || b4.pass !== 1'b0 || b4.busy !== 1'b1) begin
      errors++; $display("FAIL restart_e0: done=%0b pass=%0b busy=%0b want 0 0 1", b4.done, b4.pass, b4.busy);
    end
    mode1 = 0; b1.expected = 16'h6996;
    b1.start = 1'b1;
    tick();
    b1.start = 1'b0;
    checks++; if (b1.vec_out !== 4'd0 || b1.busy !== 1'b1) begin errors++; $display("FAIL d1_e0: vec=%0d busy=%0b want 0 1", b1.vec_out, b1.busy); end
    tick();
    checks++; if (b1.vec_out !== 4'd1) begin errors++; $display("FAIL d1_e1_vec: got %0d want 1", b1.vec_out); end
    tick();
    checks++; if (b1.vec_out !== 4'd2) begin errors++; $display("FAIL d1_e2_vec: got %0d want 2", b1.vec_out); end
    e = 2;
    while (!b1.done && e < 100) begin
      tick();
      e++;
    end
    checks++; if (e !== 16) begin errors++; $display("FAIL d1_latency: done after E%0d want E16", e); end
    checks++; if (b1.truth_table !== 16'h6996 || b1.mismatch_cnt !== 5'd0 || b1.pass !== 1'b1) begin
      errors++; $display("FAIL d1_result: tt=%h cnt=%0d pass=%0b want 6996 0 1", b1.truth_table, b1.mismatch_cnt, b1.pass);
    end
  endtask

  initial begin
    b4.start = 1'b0; b4.expected = 16'h0;
    b1.start = 1'b0; b1.expected = 16'h0;
    test_reset();
    test_pass();
    test_stuck0();
    test_all_wrong();
    test_ignored_inputs();
    test_reset_mid();
    test_restart_dwell1();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/minterm_sweep_checker.md
Name: minterm_sweep_checker

Overview:
- Synthesizable sweep-and-check stage wrapped around a 4-input combinational function block F(w,x,y,z).
- Upstream role: drives every input vector 0..2^N-1 in ascending order, holding each vector for DWELL clocks.
- Downstream role: samples F for each vector, builds the captured truth table and compares it against an expected minterm mask.
- Replaces the free-running, delay-based sweep with a clocked, self-checking sequencer.

Parameters:
- N, 4, number of function inputs; vector width N, truth-table width 2^N.
- DWELL, 4, clocks each vector is held before F is sampled; legal range 1..255.

Ports:
- clk, input, 1, system clock; all state updates on rising edge.
- rst, input, 1, synchronous active-high reset.
- start, input, 1, request a sweep; honoured only in IDLE or DONE.
- expected, input, 2^N, expected truth table; bit k = required F for vector k; latched when start is accepted.
- f_in, input, 1, output F of the function under test.
- vec_out, output, N, current input vector to the function; bit N-1 = w … bit 0 = z.
- busy, output, 1, high while in RUN.
- done, output, 1, high while in DONE.
- pass, output, 1, high in DONE when mismatch_cnt == 0; 0 in all other states.
- truth_table, output, 2^N, captured F values; bit k = F sampled for vector k.
- mismatch_cnt, output, N+1, number of vectors where F != expected; saturates at 2^N, which cannot be exceeded.
- first_bad, output, N, lowest vector index that mismatched.
- first_bad_valid, output, 1, first_bad holds a valid index.

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset values: state=IDLE; vec_out=0; busy=0; done=0; pass=0; truth_table=0; mismatch_cnt=0; first_bad=0; first_bad_valid=0; internal idx=0, dwell_cnt=0, exp_q=0.
- rst wins over every other input in the same cycle. A reset mid-sweep aborts immediately; no partial result is retained.
- State IDLE:
  - Outputs hold reset or last-cleared values.
  - start=1 at an edge → RUN; idx=0; dwell_cnt=0; exp_q=expected; truth_table, mismatch_cnt, first_bad and first_bad_valid cleared.
- State RUN:
  - vec_out=idx (registered); busy=1.
  - Each edge: if dwell_cnt != DWELL-1, dwell_cnt++.
  - Otherwise sample the vector:
    - truth_table[idx] <= f_in.
    - If f_in != exp_q[idx], mismatch_cnt++. If additionally first_bad_valid=0, first_bad<=idx and first_bad_valid<=1.
    - If idx == 2^N-1 → DONE; vec_out holds the final value 2^N-1.
    - Else idx++ and dwell_cnt=0.
  - start is ignored in RUN; expected changes after acceptance are ignored.
- State DONE:
  - done=1, busy=0, pass=(mismatch_cnt==0).
  - All results hold until the next start or rst.
  - start=1 → identical to accept in IDLE (results cleared, RUN entered); done and pass drop on that same edge.
- Timing:
  - Label the edge that accepts start as E0. Vector k is driven from E(k*DWELL) and sampled at edge E((k+1)*DWELL).
  - DONE is entered at E(2^N*DWELL). For N=4, DWELL=4, done first reads 1 after edge E64.
  - f_in must settle within DWELL-1 cycles plus combinational delay. DWELL=1 samples in the same cycle the vector is presented.
- Width rule: mismatch_cnt is N+1 bits so that an all-wrong sweep reports exactly 2^N (16).

Test Plan:
- Pass case: N=4, DWELL=4, f_in = XOR of vec_out, expected=16'h6996, pulse start → busy for 64 cycles; done after E64; truth_table=16'h6996; mismatch_cnt=0; pass=1; first_bad_valid=0.
- Stuck-at-0: f_in=0, expected=16'h6996 → truth_table=0; mismatch_cnt=8; first_bad=1; first_bad_valid=1; pass=0.
- All wrong: f_in = NOT(XOR of vec_out), expected=16'h6996 → mismatch_cnt=16 (5'b10000); first_bad=0; pass=0.
- Ignored inputs in RUN: start pulses and expected changed to 16'hFFFF at cycle 20 of a sweep → no restart; done still after E64; result checked against 16'h6996.
- Reset mid-run: assert rst at cycle 30 → next edge state=IDLE; vec_out=0; busy=0; all results 0. Then start → full 64-cycle sweep completes normally.
- Restart and DWELL=1: from DONE, pulse start → done and pass drop at E0. With DWELL=1, vec_out steps every cycle and done follows after E16.
